fetch_buffer: RTL and testbench

Instruction-fetch stage directly downstream of the program counter. Accepts each fetch address from the PC stage, issues it to the synchronous instruction memory, and queues the returned {pc, instruction} pairs in a small FIFO for the decode stage. Decouples decode stalls from PC advance and discards wrong-path fetches on a taken-branch flush driven by the PC-select signal.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_buffer.sv | 109 ++++++++++
 tb/tb_fetch_buffer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch buffer.
// The optional FETCH_BUFFER_PERF_EN build adds stall and flush counters on fetch_buffer.
package fetch_pkg;

  localparam int XLEN_DEFAULT        = 32;
  localparam int FETCH_DEPTH_DEFAULT = 4;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [XLEN_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular FIFO of fetch entries with push, pop and a synchronous clear.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = FETCH_DEPTH_DEFAULT,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Clear dominates so a flush always leaves the FIFO empty, even with a pop pending.
  assign do_push = push && !clear && (count != FULL_CNT);
  assign do_pop  = pop && !clear && !empty;

  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Fetch stage: issues PC-stage addresses to sync imem and queues {pc, instr} for decode.
// Define FETCH_BUFFER_PERF_EN to add the stall_cycles / flush_count counters.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH_DEFAULT,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [XLEN-1:0]         pc_in,
  input  logic                    pc_valid,
  output logic                    pc_ready,
  input  logic                    flush,
  output logic [XLEN-1:0]         imem_addr,
  output logic                    imem_req,
  input  logic [XLEN-1:0]         imem_rdata,
  output logic [XLEN-1:0]         instr_out,
  output logic [XLEN-1:0]         instr_pc,
  output logic                    instr_valid,
  input  logic                    instr_ready,
  output logic [$clog2(DEPTH):0]  count
`ifdef FETCH_BUFFER_PERF_EN
  ,
  output logic [31:0]             stall_cycles,
  output logic [31:0]             flush_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic [CW:0]     occupancy;
  logic            accept;
  logic            push;
  logic            pop;
  logic            fifo_empty;
  entry_t          push_data;
  entry_t          head;

  // Handshakes: a transfer happens on a cycle where valid and ready are both high;
  // ready never depends on valid, and a pop does not free space until the next cycle.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign pc_ready  = rst && !flush && (occupancy < DEPTH_W);
  assign accept    = pc_valid && pc_ready;
  assign imem_req  = accept;
  assign imem_addr = pc_in;

  // The in-flight slot is reserved in occupancy, so the returning word always has room.
  assign push      = inflight && !flush;
  assign push_data = {inflight_pc, imem_rdata};
  assign pop       = instr_valid && instr_ready && !flush;

  assign instr_valid = !fifo_empty;
  assign instr_out   = instr_valid ? head.instr : '0;
  assign instr_pc    = instr_valid ? head.pc    : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= accept;
      if (accept) inflight_pc <= pc_in;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .empty     (fifo_empty),
    .count     (count)
  );

`ifdef FETCH_BUFFER_PERF_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = pc_valid && !pc_ready && !flush;
  assign flush_evt = flush && (occupancy != '0);

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_evt && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (flush_evt && (flush_count != '1))  flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer: directed scenarios plus a randomized run
// against a queue-based reference model. Define FETCH_BUFFER_PERF_EN to cover the counters.
module tb_fetch_buffer;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [XLEN-1:0] pc_in = '0;
  logic            pc_valid = 1'b0;
  logic            pc_ready;
  logic            flush = 1'b0;
  logic [XLEN-1:0] imem_addr;
  logic            imem_req;
  logic [XLEN-1:0] imem_rdata = '0;
  logic [XLEN-1:0] instr_out;
  logic [XLEN-1:0] instr_pc;
  logic            instr_valid;
  logic            instr_ready = 1'b0;
  logic [CW-1:0]   count;
`ifdef FETCH_BUFFER_PERF_EN
  logic [31:0]     stall_cycles;
  logic [31:0]     flush_count;
`endif

  fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_valid    (pc_valid),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_addr   (imem_addr),
    .imem_req    (imem_req),
    .imem_rdata  (imem_rdata),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .count       (count)
`ifdef FETCH_BUFFER_PERF_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  // Synchronous instruction memory: word at addr is addr + 0x13.
  always @(posedge clk) imem_rdata <= imem_req ? (imem_addr + 32'h13) : 32'hDEAD_BEEF;

  // ---------------- reference model ----------------
  logic [63:0]     exp_q[$];
  bit              m_pend = 1'b0;
  logic [XLEN-1:0] m_pend_pc = '0;
  int              exp_stall = 0;
  int              exp_flushes = 0;
  int              errors = 0;
  int              checks = 0;

  function automatic bit exp_ready();
    return !flush && ((exp_q.size() + int'(m_pend)) < DEPTH);
  endfunction

  function automatic logic [XLEN-1:0] exp_head_pc();
    return (exp_q.size() != 0) ? exp_q[0][63:32] : '0;
  endfunction

  function automatic logic [XLEN-1:0] exp_head_instr();
    return (exp_q.size() != 0) ? exp_q[0][31:0] : '0;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_pend = 1'b0;
    exp_stall = 0;
    exp_flushes = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input bit pv, input logic [XLEN-1:0] pc, input bit fl, input bit rdy);
    @(negedge clk);
    pc_valid = pv;
    pc_in = pc;
    flush = fl;
    instr_ready = rdy;
    #1;
  endtask

  // Advance one clock edge and update the model from the inputs driven this cycle.
  task automatic tick();
    bit acc;
    bit pop;
    acc = pc_valid && exp_ready();
    pop = (exp_q.size() != 0) && instr_ready;
    if (pc_valid && !exp_ready() && !flush) exp_stall++;
    if (flush && ((exp_q.size() + int'(m_pend)) != 0)) exp_flushes++;
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
      m_pend = 1'b0;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (m_pend) exp_q.push_back({m_pend_pc, m_pend_pc + 32'h13});
      m_pend = acc;
      m_pend_pc = pc_in;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    pc_valid = 1'b0;
    flush = 1'b0;
    instr_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    pc_valid = 1'b1;
    pc_in = 32'h40;
    instr_ready = 1'b1;
    model_clear();
    #1;
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL reset_pc_ready: got %b want 0", pc_ready); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %b want 0", imem_req); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL reset_instr_out: got %h want 0", instr_out); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++; if (instr_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL reset_hold: valid %b count %0d want 0/0", instr_valid, count); end
    @(negedge clk);
    pc_valid = 1'b0;
    instr_ready = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_streaming(input string tag);
    for (int i = 0; i < 8; i++) begin
      bit              exp_v;
      logic [XLEN-1:0] exp_pc;
      exp_v  = (i >= 2) && (i < 6);
      exp_pc = 32'(4 * (i - 2));
      drive(i < 4, 32'(4 * i), 1'b0, 1'b1);
      checks++; if (imem_req !== (i < 4)) begin errors++; $display("FAIL %s_req c%0d: got %b want %b", tag, i, imem_req, (i < 4)); end
      if (i < 4) begin
        checks++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL %s_addr c%0d: got %h want %h", tag, i, imem_addr, 32'(4 * i)); end
      end
      checks++; if (count > 1) begin errors++; $display("FAIL %s_count c%0d: got %0d want <=1", tag, i, count); end
      checks++; if (instr_valid !== exp_v) begin errors++; $display("FAIL %s_valid c%0d: got %b want %b", tag, i, instr_valid, exp_v); end
      if (exp_v) begin
        checks++; if (instr_pc !== exp_pc) begin errors++; $display("FAIL %s_pc c%0d: got %h want %h", tag, i, instr_pc, exp_pc); end
        checks++; if (instr_out !== exp_pc + 32'h13) begin errors++; $display("FAIL %s_instr c%0d: got %h want %h", tag, i, instr_out, exp_pc + 32'h13); end
      end else begin
        checks++; if (instr_out !== 32'h0) begin errors++; $display("FAIL %s_idle_instr c%0d: got %h want 0", tag, i, instr_out); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    int              n_acc = 0;
    logic [XLEN-1:0] pc = 32'h40;
    logic [63:0]     got_q[$];
    for (int i = 0; i < 7; i++) begin
      bit acc;
      drive(1'b1, pc, 1'b0, 1'b0);
      acc = exp_ready();
      checks++; if (imem_req !== acc) begin errors++; $display("FAIL bp_req c%0d: got %b want %b", i, imem_req, acc); end
      if (imem_req === 1'b1) n_acc++;
      tick();
      if (acc) pc += 4;
    end
    drive(1'b1, pc, 1'b0, 1'b0);
    checks++; if (n_acc != 4) begin errors++; $display("FAIL bp_accepts: got %0d want 4", n_acc); end
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready: got %b want 0", pc_ready); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL bp_full_req: got %b want 0", imem_req); end
    checks++; if (count !== CW'(4)) begin errors++; $display("FAIL bp_full_count: got %0d want 4", count); end
    tick();
    drive(1'b1, pc, 1'b0, 1'b1);
    checks++; if (pc_ready !== 1'b0) begin errors++; $display("FAIL bp_pop_cycle_ready: got %b want 0", pc_ready); end
    if (instr_valid === 1'b1) got_q.push_back({instr_pc, instr_out});
    tick();
    drive(1'b1, pc, 1'b0, 1'b1);
    checks++; if (pc_ready !== 1'b1) begin errors++; $display("FAIL bp_after_pop_ready: got %b want 1", pc_ready); end
    if (instr_valid === 1'b1) got_q.push_back({instr_pc, instr_out});
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, '0, 1'b0, 1'b1);
      if (instr_valid === 1'b1) got_q.push_back({instr_pc, instr_out});
      tick();
    end
    checks++; if (got_q.size() != 5) begin errors++; $display("FAIL bp_drain_size: got %0d want 5", got_q.size()); end
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      logic [XLEN-1:0] want_pc;
      want_pc = 32'h40 + 32'(4 * i);
      checks++; if (got_q[i] !== {want_pc, want_pc + 32'h13}) begin errors++; $display("FAIL bp_drain_entry%0d: got %h want %h", i, got_q[i], {want_pc, want_pc + 32'h13}); end
    end
  endtask

  task automatic test_inflight_flush();
    drive(1'b1, 32'h10, 1'b0, 1'b1);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ifl_first_req: got %b want 1", imem_req); end
    tick();
    drive(1'b1, 32'h100, 1'b1, 1'b1);
    checks++; if (pc_ready !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL ifl_flush_cycle: ready %b req %b want 0/0", pc_ready, imem_req); end
    tick();
    drive(1'b1, 32'h100, 1'b0, 1'b1);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ifl_new_req: got %b want 1", imem_req); end
    checks++; if (count !== '0 || instr_valid !== 1'b0) begin errors++; $display("FAIL ifl_dropped: count %0d valid %b want 0/0", count, instr_valid); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ifl_wait: got %b want 0", instr_valid); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr_out !== 32'h113) begin errors++; $display("FAIL ifl_new_head: valid %b pc %h instr %h want 1/100/113", instr_valid, instr_pc, instr_out); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b1);
    checks++; if (instr_valid !== 1'b0 || count !== '0) begin errors++; $display("FAIL ifl_drained: valid %b count %0d want 0/0", instr_valid, count); end
    tick();
  endtask

  task automatic test_flush_full();
    logic [XLEN-1:0] pc = 32'h200;
    for (int i = 0; i < 6; i++) begin
      bit acc;
      drive(1'b1, pc, 1'b0, 1'b0);
      acc = exp_ready();
      tick();
      if (acc) pc += 4;
    end
    drive(1'b1, pc, 1'b1, 1'b1);
    checks++; if (count !== CW'(4) || instr_valid !== 1'b1) begin errors++; $display("FAIL ff_full: count %0d valid %b want 4/1", count, instr_valid); end
    checks++; if (pc_ready !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL ff_flush_ready: ready %b req %b want 0/0", pc_ready, imem_req); end
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (count !== '0 || instr_valid !== 1'b0) begin errors++; $display("FAIL ff_after: count %0d valid %b want 0/0", count, instr_valid); end
    checks++; if (instr_out !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL ff_after_data: instr %h pc %h want 0/0", instr_out, instr_pc); end
    tick();
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    #2;
    checks++; if (count !== CW'(3)) begin errors++; $display("FAIL mr_setup_count: got %0d want 3", count); end
    rst = 1'b0;
    #1;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %b want 0", instr_valid); end
    checks++; if (pc_ready !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL mr_ready: ready %b req %b want 0/0", pc_ready, imem_req); end
    checks++; if (count !== '0) begin errors++; $display("FAIL mr_count: got %0d want 0", count); end
    model_clear();
    @(posedge clk);
    @(negedge clk);
    pc_valid = 1'b0;
    instr_ready = 1'b0;
    rst = 1'b1;
    test_streaming("mr_stream");
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit              pv;
      bit              fl;
      bit              rdy;
      bit              er;
      logic [XLEN-1:0] pc;
      pv  = ($urandom_range(0, 3) != 0);
      fl  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 9) < (((i / 100) % 2) ? 8 : 2));
      pc  = $urandom & 32'hFFFF_FFFC;
      drive(pv, pc, fl, rdy);
      er = exp_ready();
      checks++; if (pc_ready !== er) begin errors++; $display("FAIL rnd_ready c%0d: got %b want %b", i, pc_ready, er); end
      checks++; if (imem_req !== (pv && er)) begin errors++; $display("FAIL rnd_req c%0d: got %b want %b", i, imem_req, pv && er); end
      if (pv && er) begin
        checks++; if (imem_addr !== pc) begin errors++; $display("FAIL rnd_addr c%0d: got %h want %h", i, imem_addr, pc); end
      end
      checks++; if (count !== CW'(exp_q.size())) begin errors++; $display("FAIL rnd_count c%0d: got %0d want %0d", i, count, exp_q.size()); end
      checks++; if (instr_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", i, instr_valid, exp_q.size() != 0); end
      checks++; if (instr_pc !== exp_head_pc() || instr_out !== exp_head_instr()) begin errors++; $display("FAIL rnd_head c%0d: got %h/%h want %h/%h", i, instr_pc, instr_out, exp_head_pc(), exp_head_instr()); end
      tick();
    end
`ifdef FETCH_BUFFER_PERF_EN
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (stall_cycles !== 32'(exp_stall)) begin errors++; $display("FAIL rnd_stall_cycles: got %0d want %0d", stall_cycles, exp_stall); end
    checks++; if (flush_count !== 32'(exp_flushes)) begin errors++; $display("FAIL rnd_flush_count: got %0d want %0d", flush_count, exp_flushes); end
    tick();
`endif
  endtask

`ifdef FETCH_BUFFER_PERF_EN
  task automatic test_perf();
    apply_reset();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin errors++; $display("FAIL perf_reset: stall %0d flush %0d want 0/0", stall_cycles, flush_count); end
    tick();
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 32'h400 + 32'(4 * i), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 32'h500, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0);
    checks++; if (stall_cycles !== 32'd5) begin errors++; $display("FAIL perf_stall_cycles: got %0d want 5", stall_cycles); end
    checks++; if (flush_count !== 32'd2) begin errors++; $display("FAIL perf_flush_count: got %0d want 2", flush_count); end
    tick();
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    apply_reset();
    test_reset();
    test_streaming("stream");
    test_backpressure();
    test_inflight_flush();
    test_flush_full();
    test_mid_reset();
    test_random();
`ifdef FETCH_BUFFER_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
